b_resp_tracker: RTL and testbench
=================================

Name: b_resp_tracker

Overview:
Parametrised write-response (B) channel tracker for the SRAM-to-AXI bridge. Supports multiple requester IDs, each with several writes outstanding.
- Counts writes issued per ID and accepts AXI B responses.
- Returns a one-cycle data_ok pulse to the owning requester.
- Exports per-ID full flags and an idle flag for address-channel throttling and read-after-write ordering.

Parameters:
ID_W, 4, width of AXI bid and of wr_issue_id.
N_ID, 2, number of tracked requester IDs; tracked IDs are BASE_ID .. BASE_ID+N_ID-1.
BASE_ID, 0, AXI ID of requester 0.
CNT_W, 3, width of each outstanding counter; at most 2^CNT_W-1 writes outstanding per ID.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous active-low reset; sampled on the clk edge, 0 = reset.
wr_issue  input  1  one-cycle pulse; a write has completed its AW/W handshake.
wr_issue_id  input  ID_W  AXI ID of the issued write.
wr_full  output  N_ID  bit i = counter i at maximum (2^CNT_W-1).
wr_idle  output  1  all counters zero.
bid  input  ID_W  AXI B id.
bresp  input  2  AXI B response.
bvalid  input  1  AXI B valid.
bready  output  1  AXI B ready; registered.
data_ok  output  N_ID  bit i pulses one cycle when a write of requester i completes; registered.
err_valid  output  1  sticky error flag (feature only; tied 0 otherwise).
err_id  output  ID_W  bid of the first error captured.
err_resp  output  2  bresp of the first error captured.
err_clr  input  1  clears the error capture (ignored when the feature is absent).

Behaviour:
- Reset (reset=0 at an edge), including mid-transaction:
  - all counters 0, bready=0, data_ok=0, err_valid=0, err_id=0, err_resp=0.
  - In-flight responses are forgotten; the bridge is reset together with this block.
- Handshake: hs = bvalid & bready. Index k = bid-BASE_ID; the ID is in range when 0 <= k < N_ID (compare in ID_W+1 bits, no wrap).
- Issue: when wr_issue is 1 and wr_issue_id is in range, cnt[wr_issue_id-BASE_ID] increments.
  - Issue while wr_full for that ID: ignored, counter saturates. The upstream logic must use wr_full to prevent this.
  - Out-of-range issue ID: ignored.
- Retire: when hs is 1, bid is in range and cnt[k] > 0, cnt[k] decrements and data_ok[k]=1 in the next cycle only.
- Same cycle, same ID, issue and retire: counter unchanged; data_ok still pulses.
- Stray response (hs with bid out of range, or cnt[k]==0): still accepted and dropped. No data_ok, no counter change; it is an error condition when the feature is enabled.
- bready register:
  - next value = (any next-state counter > 0) & ~hs.
  - bready deasserts for one cycle after every handshake, so at most one response is accepted per two cycles. This gives the bridge a response-drain cycle and guarantees data_ok pulses never merge.
  - First issue at cycle T -> bready=1 at T+1.
- data_ok latency: handshake at edge T -> data_ok[k] high from T to T+1.
- bresp is ignored for completion: SLVERR/DECERR still retire the write and pulse data_ok.
- wr_full and wr_idle are combinational from the counter registers only; there is no combinational path from bvalid or wr_issue.
- Counter arithmetic is CNT_W bits unsigned; underflow is impossible by the retire guard.

Optional Feature:
Macro B_RESP_ERR_EN.
- Defined:
  - Captures the first error into err_valid/err_id/err_resp. An error is a handshake with bresp != 2'b00, or a stray response as defined above.
  - Later errors do not overwrite the capture while err_valid=1.
  - err_clr=1 clears err_valid at the next edge. If an error occurs in the same cycle as err_clr, that new error is captured; clear loses.
- Not defined:
  - err_valid, err_id and err_resp are constant 0, err_clr is unused, and no capture registers are synthesised.

Test Plan:
- Reset: hold reset=0 with bvalid=1 -> bready=0, data_ok=0, wr_idle=1; release reset -> bready stays 0 until the first wr_issue.
- Single write: wr_issue id=0 at cycle 2, bvalid id=0 bresp=0 from cycle 4 -> handshake at 4, data_ok=2'b01 at cycle 5 only, bready=0 at 5, wr_idle=1 at 5.
- Multiple outstanding: 3 issues id=1 then 3 back-to-back B id=1 -> bready toggles 1,0,1,0,1; data_ok[1] pulses 3 times with one-cycle gaps; the counter reaches 0.
- Full/saturation (CNT_W=3): 7 issues id=0 -> wr_full[0]=1; 8th issue ignored; one B retire -> wr_full[0]=0, counter=6.
- Simultaneous issue and retire, id=0, counter=2 -> counter stays 2 and data_ok[0] pulses.
- With B_RESP_ERR_EN: B id=0 bresp=2'b10, then stray bid=5 -> err_valid=1, err_id=0, err_resp=2; err_clr -> err_valid=0. Without the macro: the same stimulus leaves err_valid=0 and data_ok still pulses for the id=0 write.

Source files
------------

// File: rtl/b_resp_tracker.sv
// AXI B-channel tracker: per-requester outstanding-write counters, data_ok pulses, throttling flags.
// Optional first-error capture is built when B_RESP_ERR_EN is defined.
module b_resp_tracker #(
  parameter int ID_W    = 4,
  parameter int N_ID    = 2,
  parameter int BASE_ID = 0,
  parameter int CNT_W   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_issue,
  input  logic [ID_W-1:0] wr_issue_id,
  output logic [N_ID-1:0] wr_full,
  output logic            wr_idle,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  output logic [N_ID-1:0] data_ok,
  output logic            err_valid,
  output logic [ID_W-1:0] err_id,
  output logic [1:0]      err_resp,
  input  logic            err_clr
);

  localparam logic [ID_W:0]    ID_LO   = (ID_W+1)'(BASE_ID);
  localparam logic [ID_W:0]    ID_HI   = (ID_W+1)'(BASE_ID + N_ID);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Range check is done one bit wider so IDs below BASE_ID cannot wrap into range.
  function automatic logic id_in_range(input logic [ID_W-1:0] id);
    return ({1'b0, id} >= ID_LO) && ({1'b0, id} < ID_HI);
  endfunction

  function automatic logic [ID_W:0] id_index(input logic [ID_W-1:0] id);
    return {1'b0, id} - ID_LO;
  endfunction

  logic [N_ID-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       bready_q, bready_d;
  logic [N_ID-1:0]            data_ok_q, data_ok_d;
  logic                       hs;
  logic                       iss_ok;
  logic                       bid_ok;
  logic [ID_W:0]              iss_k;
  logic [ID_W:0]              bid_k;
  logic                       retire_any;

  // Next-state counters, completion pulses and bready.
  always_comb begin
    logic inc;
    logic dec;
    hs         = bvalid & bready_q;
    iss_ok     = wr_issue & id_in_range(wr_issue_id);
    bid_ok     = hs & id_in_range(bid);
    iss_k      = id_index(wr_issue_id);
    bid_k      = id_index(bid);
    cnt_d      = cnt_q;
    data_ok_d  = '0;
    retire_any = 1'b0;
    inc        = 1'b0;
    dec        = 1'b0;
    for (int i = 0; i < N_ID; i++) begin
      inc          = iss_ok && (iss_k == (ID_W+1)'(i));
      dec          = bid_ok && (bid_k == (ID_W+1)'(i)) && (cnt_q[i] != '0);
      data_ok_d[i] = dec;
      retire_any   = retire_any | dec;
      // A retire frees a slot, so a concurrent issue on the same ID is net-neutral even when full.
      if (inc && dec) begin
        cnt_d[i] = cnt_q[i];
      end else if (inc && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    bready_d = (cnt_d != '0) & ~hs;
  end

  // Throttling flags come from registered counters only.
  always_comb begin
    wr_full = '0;
    for (int i = 0; i < N_ID; i++) begin
      wr_full[i] = (cnt_q[i] == CNT_MAX);
    end
    wr_idle = (cnt_q == '0);
  end

  // Counter, bready and data_ok registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      bready_q  <= 1'b0;
      data_ok_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      bready_q  <= bready_d;
      data_ok_q <= data_ok_d;
    end
  end

  assign bready  = bready_q;
  assign data_ok = data_ok_q;

`ifdef B_RESP_ERR_EN
  logic            err_valid_q, err_valid_d;
  logic [ID_W-1:0] err_id_q, err_id_d;
  logic [1:0]      err_resp_q, err_resp_d;
  logic            err_evt;

  // First-error capture; a new error in the clear cycle wins over the clear.
  always_comb begin
    err_evt     = hs & ((bresp != 2'b00) | ~retire_any);
    err_valid_d = err_valid_q;
    err_id_d    = err_id_q;
    err_resp_d  = err_resp_q;
    if (err_evt && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_id_d    = bid;
      err_resp_d  = bresp;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
      err_id_d    = '0;
      err_resp_d  = 2'b00;
    end else begin
      err_valid_d = err_valid_q;
    end
  end

  // Error capture registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
      err_resp_q  <= 2'b00;
    end else begin
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
      err_resp_q  <= err_resp_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_id    = err_id_q;
  assign err_resp  = err_resp_q;
`else
  logic unused_err_in;
  assign unused_err_in = ^{err_clr, retire_any, bresp};
  assign err_valid     = 1'b0;
  assign err_id        = '0;
  assign err_resp      = 2'b00;
`endif

endmodule

// File: tb/tb_b_resp_tracker.sv
// Bench for b_resp_tracker: directed vector table plus randomized traffic against a counting model.
module tb_b_resp_tracker;
  localparam int ID_W    = 4;
  localparam int N_ID    = 2;
  localparam int BASE_ID = 0;
  localparam int CNT_W   = 3;
  localparam int MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, wr_issue, bvalid, bready, wr_idle, err_valid, err_clr;
  logic [ID_W-1:0] wr_issue_id, bid, err_id;
  logic [1:0]      bresp, err_resp;
  logic [N_ID-1:0] wr_full, data_ok;

  b_resp_tracker #(.ID_W(ID_W), .N_ID(N_ID), .BASE_ID(BASE_ID), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_issue(wr_issue), .wr_issue_id(wr_issue_id),
    .wr_full(wr_full), .wr_idle(wr_idle), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .data_ok(data_ok), .err_valid(err_valid), .err_id(err_id),
    .err_resp(err_resp), .err_clr(err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding writes per requester plus acceptor state.
  int m_cnt[N_ID];
  bit m_bready;
  int m_dok;
  bit m_ev;
  int m_eid, m_er;

  typedef struct {
    logic       r, i;
    logic [3:0] iid;
    logic       v;
    logic [3:0] b;
    logic [1:0] br;
    logic       c;
    logic       rdy;
    logic [1:0] dok, full;
    logic       idle, ev;
    logic [3:0] eid;
    logic [1:0] er;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    int pre[N_ID];
    int ik, bk;
    bit hs, ret, evt;
    if (!reset) begin
      foreach (m_cnt[n]) m_cnt[n] = 0;
      m_bready = 0; m_dok = 0; m_ev = 0; m_eid = 0; m_er = 0;
      return;
    end
    hs  = bvalid && m_bready;
    ik  = int'(wr_issue_id) - BASE_ID;
    bk  = int'(bid) - BASE_ID;
    pre = m_cnt;
    ret = hs && (bk >= 0) && (bk < N_ID) && (pre[bk] > 0);
    m_dok = 0;
    if (ret) begin
      m_cnt[bk] = m_cnt[bk] - 1;
      m_dok = 1 << bk;
    end
    if (wr_issue && (ik >= 0) && (ik < N_ID) && ((pre[ik] < MAX) || (ret && bk == ik)))
      m_cnt[ik] = m_cnt[ik] + 1;
    m_bready = 0;
    foreach (m_cnt[n]) if (m_cnt[n] > 0) m_bready = !hs;
    evt = hs && ((bresp != 2'b00) || !ret);
    if (evt && (!m_ev || err_clr)) begin
      m_ev = 1; m_eid = int'(bid); m_er = int'(bresp);
    end else if (err_clr) begin
      m_ev = 0; m_eid = 0; m_er = 0;
    end
  endtask

  task automatic check_model(input string tag);
    int efull, eidle;
    efull = 0; eidle = 1;
    foreach (m_cnt[n]) begin
      if (m_cnt[n] == MAX) efull |= (1 << n);
      if (m_cnt[n] != 0) eidle = 0;
    end
    chk({tag, ".bready"},  32'(bready),  32'(m_bready));
    chk({tag, ".data_ok"}, 32'(data_ok), 32'(m_dok));
    chk({tag, ".wr_full"}, 32'(wr_full), 32'(efull));
    chk({tag, ".wr_idle"}, 32'(wr_idle), 32'(eidle));
`ifdef B_RESP_ERR_EN
    chk({tag, ".err_valid"}, 32'(err_valid), 32'(m_ev));
    chk({tag, ".err_id"},    32'(err_id),    32'(m_eid));
    chk({tag, ".err_resp"},  32'(err_resp),  32'(m_er));
`else
    chk({tag, ".err_valid"}, 32'(err_valid), 32'd0);
`endif
  endtask

  task automatic step(input logic r, input logic i, input logic [3:0] iid, input logic v,
                      input logic [3:0] b, input logic [1:0] br, input logic c, input string tag);
    reset = r; wr_issue = i; wr_issue_id = iid; bvalid = v; bid = b; bresp = br; err_clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic add(input logic r, input logic i, input logic [3:0] iid, input logic v,
                     input logic [3:0] b, input logic [1:0] br, input logic c,
                     input logic rdy, input logic [1:0] dok, input logic [1:0] full,
                     input logic idle, input logic ev, input logic [3:0] eid, input logic [1:0] er);
    vec_t t;
    t.r = r; t.i = i; t.iid = iid; t.v = v; t.b = b; t.br = br; t.c = c;
    t.rdy = rdy; t.dok = dok; t.full = full; t.idle = idle; t.ev = ev; t.eid = eid; t.er = er;
    vecs.push_back(t);
  endtask

  initial begin
    string tag;
    reset = 1'b0; wr_issue = 1'b0; wr_issue_id = '0; bvalid = 1'b0; bid = '0; bresp = 2'b00;
    err_clr = 1'b0;
    foreach (m_cnt[n]) m_cnt[n] = 0;
    m_bready = 0; m_dok = 0; m_ev = 0; m_eid = 0; m_er = 0;
    @(negedge clk);

    //   r  i  iid v  b  br c | rdy dok full idle ev eid er
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);  // reset held with bvalid
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);  // released: bready stays low
    add(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);  // single write id0
    add(1, 0, 0, 1, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);  // three writes id1
    add(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0,  0, 2, 0, 0, 0, 0, 0);  // back-to-back B id1
    add(1, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0,  0, 2, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0,  0, 2, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    for (int n = 0; n < 6; n++)
      add(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);  // fill id0
    add(1, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);  // 7th: full
    add(1, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);  // 8th ignored
    add(1, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);  // retire -> 6
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);  // mid-traffic reset
    add(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);  // issue+retire id0, count stays 2
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 2, 0,  0, 1, 0, 0, 1, 0, 2);  // SLVERR still retires
    add(1, 0, 0, 1, 5, 0, 0,  1, 0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0, 1, 0, 2);  // stray bid5 dropped
    add(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);  // err_clr
    add(1, 0, 0, 1, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[n]) begin
      tag = $sformatf("v%0d", n);
      step(vecs[n].r, vecs[n].i, vecs[n].iid, vecs[n].v, vecs[n].b, vecs[n].br, vecs[n].c, tag);
      chk({tag, ".tbl_bready"},  32'(bready),  32'(vecs[n].rdy));
      chk({tag, ".tbl_data_ok"}, 32'(data_ok), 32'(vecs[n].dok));
      chk({tag, ".tbl_wr_full"}, 32'(wr_full), 32'(vecs[n].full));
      chk({tag, ".tbl_wr_idle"}, 32'(wr_idle), 32'(vecs[n].idle));
`ifdef B_RESP_ERR_EN
      chk({tag, ".tbl_err_valid"}, 32'(err_valid), 32'(vecs[n].ev));
      chk({tag, ".tbl_err_id"},    32'(err_id),    32'(vecs[n].eid));
      chk({tag, ".tbl_err_resp"},  32'(err_resp),  32'(vecs[n].er));
`endif
    end

    for (int n = 0; n < 600; n++) begin
      step(logic'($urandom_range(63) != 0), logic'($urandom_range(1)), 4'($urandom_range(3)),
           logic'($urandom_range(2) != 0), 4'($urandom_range(5)),
           ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00,
           logic'($urandom_range(15) == 0), $sformatf("r%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
